// File: rtl/pipemem_stage.sv
// MEM stage of the 5-stage pipeline: data RAM with MEM_LAT wait states plus the MEM/WB register.
// Optional memory-mapped I/O (in_port/out_port) is compiled in when PIPEMEM_IO_EN is defined.
module pipemem_stage #(
  parameter int ADDR_WIDTH = 6,
  parameter int MEM_LAT    = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  input  logic [31:0] in_port,
  output logic        stall_mem,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic [4:0]  wrn,
  output logic [31:0] out_port
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam bit         HAS_LAT = (MEM_LAT > 0);
  localparam logic [2:0] LAT_M1  = 3'(MEM_LAT - 1);
  localparam int         DEPTH   = 2 ** ADDR_WIDTH;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       ram [0:DEPTH-1];
  logic [ADDR_WIDTH-1:0] idx;
  logic              is_io, ram_acc, complete, stall_c, ram_we, io_we;
  logic [31:0]       io_rd;
  logic              wwreg_q, wwreg_d, wm2reg_q, wm2reg_d;
  logic [31:0]       wmo_q, wmo_d, walu_q, walu_d, out_port_q, out_port_d;
  logic [4:0]        wrn_q, wrn_d;

  assign idx = malu[ADDR_WIDTH+1:2];

`ifdef PIPEMEM_IO_EN
  assign is_io = malu[31];
  always_comb begin
    io_rd = 32'h0;
    if (malu == 32'h8000_0000)
      io_rd = in_port;
    else if (malu == 32'h8000_0004)
      io_rd = out_port_q;
  end
  assign io_we = complete & mwmem & is_io & (malu == 32'h8000_0004);
`else
  logic unused_in_port;
  assign unused_in_port = ^in_port;
  assign is_io = 1'b0;
  assign io_rd = 32'h0;
  assign io_we = 1'b0;
`endif

  assign ram_acc = (mm2reg | mwmem) & ~is_io;

  // Control: a RAM access is held in WAIT until cnt drains; reset suppresses stall and commit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ram_acc && HAS_LAT) begin
          stall_c = 1'b1;
          cnt_d   = LAT_M1;
          state_d = S_WAIT;
        end else begin
          complete = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q != 3'd0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 3'd1;
        end else begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (reset) begin
      stall_c  = 1'b0;
      complete = 1'b0;
    end
  end

  assign ram_we = complete & mwmem & ~is_io;

  // Read data is taken before the write edge, so a load+store pair sees the old word.
  always_comb begin
    wwreg_d    = 1'b0;
    wm2reg_d   = 1'b0;
    wmo_d      = 32'h0;
    walu_d     = 32'h0;
    wrn_d      = 5'd0;
    out_port_d = io_we ? mb : out_port_q;
    if (complete) begin
      wwreg_d  = mwreg;
      wm2reg_d = mm2reg;
      walu_d   = malu;
      wrn_d    = mrn;
      if (mm2reg)
        wmo_d = is_io ? io_rd : ram[idx];
    end
  end

  always_ff @(posedge clock) begin
    if (ram_we)
      ram[idx] <= mb;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      wwreg_q    <= 1'b0;
      wm2reg_q   <= 1'b0;
      wmo_q      <= 32'h0;
      walu_q     <= 32'h0;
      wrn_q      <= 5'd0;
      out_port_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wwreg_q    <= wwreg_d;
      wm2reg_q   <= wm2reg_d;
      wmo_q      <= wmo_d;
      walu_q     <= walu_d;
      wrn_q      <= wrn_d;
      out_port_q <= out_port_d;
    end
  end

  assign stall_mem = stall_c;
  assign wwreg     = wwreg_q;
  assign wm2reg    = wm2reg_q;
  assign wmo       = wmo_q;
  assign walu      = walu_q;
  assign wrn       = wrn_q;
  assign out_port  = out_port_q;

endmodule

// File: doc/pipemem_stage.md
# pipemem_stage

Memory stage of the 5-stage pipelined CPU, placed between the EX/MEM register and the WB stage. It consumes the EX/MEM outputs (write-enable flags, ALU result, store data, destination register) and performs data-RAM or memory-mapped I/O accesses. RAM accesses have a configurable number of wait states, during which the block stalls the upstream pipeline. Results are registered as the MEM/WB pipeline register.

## Interface
- `ADDR_WIDTH`, default 6: word-address width of the data RAM (2^ADDR_WIDTH 32-bit words).
- `MEM_LAT`, default 2: RAM wait states per access, range 0..7.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `mwreg` in 1: register write enable from EX/MEM.
- `mm2reg` in 1: load select from EX/MEM.
- `mwmem` in 1: store enable from EX/MEM.
- `malu` in 32: byte address or ALU result.
- `mb` in 32: store data.
- `mrn` in 5: destination register.
- `in_port` in 32: external input word, memory-mapped I/O.
- `stall_mem` out 1: combinational; freezes PC, IF/ID, ID/EX and EX/MEM while high.
- `wwreg`, `wm2reg` out 1 each: MEM/WB control outputs.
- `wmo` out 32: load data.
- `walu` out 32: registered copy of `malu`.
- `wrn` out 5: registered copy of `mrn`.
- `out_port` out 32: memory-mapped output register.

## Operation
- **Access classification:**
  - An access is pending when `mm2reg|mwmem`.
  - It is an I/O access if `malu[31]=1`; otherwise it is a RAM access.
  - The RAM word index is `malu[ADDR_WIDTH+1:2]`. Upper bits and `malu[1:0]` are ignored, so addresses wrap modulo the RAM size.
- **I/O map:**
  - `0x8000_0000` read returns `in_port`.
  - `0x8000_0004` read returns `out_port`; a write loads `out_port`.
  - Other I/O addresses read 0 and ignore writes.
  - I/O accesses never stall.
- **FSM states:** IDLE and WAIT, plus a 3-bit counter `cnt`.
- **IDLE transitions:**
  - If a RAM access is pending and `MEM_LAT>0`, assert `stall_mem`, load `cnt=MEM_LAT-1`, and go to WAIT. Do not perform the access.
  - Otherwise, complete the access this cycle.
- **WAIT transitions:**
  - If `cnt!=0`, assert `stall_mem` and decrement `cnt`.
  - If `cnt==0`, deassert `stall_mem`, complete the access, and return to IDLE.
- **Completion cycle:**
  - A store writes `mb` to RAM (or `out_port`) exactly once.
  - A load places the RAM or I/O word into `wmo`.
  - A non-memory instruction loads `wmo` with 0.
  - `wwreg`, `wm2reg`, `walu` and `wrn` are loaded from their inputs.
- **Stall cycles:**
  - The MEM/WB register loads a bubble: `wwreg=0`, `wm2reg=0`, `wrn=0`, `walu=0`, `wmo=0`.
  - Inputs are held stable by the upstream freeze.
- **Simultaneous `mm2reg` and `mwmem` (illegal encoding):** treated as a store. `wmo` receives the pre-write contents of the addressed word.
- **Reset:**
  - All outputs go to 0, including `out_port` and `stall_mem`. The FSM goes to IDLE with `cnt=0`.
  - An in-flight store is discarded.
  - RAM contents are not cleared.

## Timing
- Non-RAM instruction: MEM/WB outputs are valid 1 cycle after the instruction is present at the inputs.
- RAM access: `stall_mem` is high for exactly `MEM_LAT` consecutive cycles, starting in the first cycle the access is presented. Results are valid `MEM_LAT+1` cycles after presentation.
- `MEM_LAT=0`: all accesses are single-cycle and `stall_mem` stays 0.
- Back-to-back RAM accesses each incur a full `MEM_LAT`. There is no overlap, and the second access starts in the cycle after the first completes.
- Store followed by a load to the same word: the load returns the new data, because the store commits before the next instruction enters the stage.
- `stall_mem` depends only on the FSM state and the current inputs, not on downstream state.
- `reset` asserted during WAIT: the next cycle is IDLE with `stall_mem=0`.

## Configuration
- **`PIPEMEM_IO_EN` defined:** the I/O decode above is present, `in_port` is sampled, and `out_port` is a register.
- **`PIPEMEM_IO_EN` undefined:**
  - `malu[31]` is ignored, and every access is a RAM access with the normal stall behaviour.
  - `out_port` is tied to 0 and `in_port` is unused.

## Test plan
- **Reset:** hold `reset=1` for 2 cycles → every output is 0 and `stall_mem=0`. Release, then apply an ALU op (`mwreg=1`, `malu=0x1234`, `mrn=5`) → next cycle `wwreg=1`, `walu=0x1234`, `wrn=5`, `wmo=0`.
- **Store then load, `MEM_LAT=2`:**
  - Store `mb=0xDEADBEEF` to `0x10`: `stall_mem` is high for 2 cycles, then the write commits.
  - Load from `0x10` → `stall_mem` is high for 2 cycles, then `wmo=0xDEADBEEF`, `wm2reg=1`.
  - MEM/WB shows a bubble (`wwreg=0`) during each stall.
- **I/O, with `PIPEMEM_IO_EN`:**
  - Store `0xA5` to `0x8000_0004` → `out_port=0xA5` after 1 cycle, no stall.
  - With `in_port=0x77`, load `0x8000_0000` → `wmo=0x77` after 1 cycle.
- **Address wrap, `ADDR_WIDTH=6`:** store `0x11` to `0x100`, then load from `0x000` → `wmo=0x11`.
- **Reset mid-WAIT:** start a store of `0x55` to `0x20`, assert `reset` in the first WAIT cycle → `stall_mem=0` the next cycle, and a later load of `0x20` returns the old value.
- **`MEM_LAT=0`:** a store to `0x8` followed by a load from `0x8` on consecutive cycles → no stall, and the load returns the stored value.
